// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution engine input stream.
// The engine uses the filter-length constants as well.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_FILT = 3'd1,
    GAP       = 3'd2,
    SEND_IMG  = 3'd3,
    WAIT_OUT  = 3'd4
  } feed_state_t;

  localparam int FILT3_LEN    = 9;
  localparam int FILT5_LEN    = 25;
  localparam int MAX_FILT_LEN = 25;

  // Filter burst length: filter_size 0 = 3x3, 1 = 5x5.
  function automatic logic [4:0] filt_len(input logic filter_size);
    return filter_size ? 5'(FILT5_LEN) : 5'(FILT3_LEN);
  endfunction

endpackage

// File: rtl/feed_buf.sv
// Byte array with one write port and one combinational read port.
// A write to the address being read is forwarded so it is visible the same cycle.
module feed_buf #(
  parameter int DEPTH = 25,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata = '0;
    if (we && (waddr == raddr)) rdata = wdata;
    else if (int'(raddr) < DEPTH) rdata = mem[raddr];
  end

endmodule

// File: rtl/conv_feeder.sv
// Streams one convolution job (config, filter burst, gap, image burst) to the engine
// and counts its result pulses until the job completes or the watchdog expires.
module conv_feeder #(
  parameter int MAX_IMG = 8,
  parameter int GAP_CYC = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_we,
  input  logic       host_sel,
  input  logic [5:0] host_addr,
  input  logic [7:0] host_wdata,
  input  logic       start,
  input  logic       cfg_filter_size,
  input  logic [3:0] cfg_image_size,
  input  logic       cfg_pad_mode,
  input  logic       cfg_act_mode,
  output logic       busy,
  output logic       done,
  output logic       cfg_err,
  output logic       timeout_err,
  output logic       filter_valid,
  output logic       image_valid,
  output logic       filter_size,
  output logic [3:0] image_size,
  output logic       pad_mode,
  output logic       act_mode,
  output logic [7:0] in_data,
  input  logic       conv_out_valid
);
  import conv_pkg::*;

  localparam int IMG_DEPTH = MAX_IMG * MAX_IMG;
  localparam int IMG_AW    = $clog2(IMG_DEPTH);
  localparam int FILT_AW   = $clog2(MAX_FILT_LEN);
  localparam int WD_W      = $clog2(TIMEOUT + 1);

  feed_state_t     state;
  logic [6:0]      idx;
  logic [6:0]      nn;
  logic [6:0]      res_cnt;
  logic [3:0]      gap_cnt;
  logic [WD_W-1:0] wdog;

  logic               filt_we, img_we;
  logic [FILT_AW-1:0] filt_raddr;
  logic [IMG_AW-1:0]  img_raddr;
  logic [7:0]         filt_rdata, img_rdata;
  logic [6:0]         img_sq, res_next;
  logic               cfg_bad, end_ok, end_tmo;

  // Buffers only accept host writes while idle; out-of-range addresses are dropped.
  assign filt_we = host_we && !host_sel && (state == IDLE) && (int'(host_addr) < MAX_FILT_LEN);
  assign img_we  = host_we &&  host_sel && (state == IDLE) && (int'(host_addr) < IMG_DEPTH);

  assign filt_raddr = (state == SEND_FILT) ? idx[FILT_AW-1:0] : '0;
  assign img_raddr  = (state == SEND_IMG)  ? idx[IMG_AW-1:0]  : '0;

  feed_buf #(.DEPTH(MAX_FILT_LEN), .AW(FILT_AW)) u_filt_buf (
    .clk   (clk),
    .we    (filt_we),
    .waddr (host_addr[FILT_AW-1:0]),
    .wdata (host_wdata),
    .raddr (filt_raddr),
    .rdata (filt_rdata)
  );

  feed_buf #(.DEPTH(IMG_DEPTH), .AW(IMG_AW)) u_img_buf (
    .clk   (clk),
    .we    (img_we),
    .waddr (host_addr[IMG_AW-1:0]),
    .wdata (host_wdata),
    .raddr (img_raddr),
    .rdata (img_rdata)
  );

  assign img_sq   = {3'd0, cfg_image_size} * {3'd0, cfg_image_size};
  assign cfg_bad  = (cfg_image_size == 4'd0) || (int'(cfg_image_size) > MAX_IMG);
  assign res_next = res_cnt + 7'((conv_out_valid && (res_cnt != nn)) ? 1 : 0);
  // The job can finish on the last image byte if every result is already in.
  assign end_ok   = ((state == SEND_IMG && idx == nn) || state == WAIT_OUT) && (res_next == nn);
  assign end_tmo  = (state == WAIT_OUT) && !end_ok && !conv_out_valid &&
                    (wdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      nn           <= '0;
      res_cnt      <= '0;
      gap_cnt      <= '0;
      wdog         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      timeout_err  <= 1'b0;
      filter_valid <= 1'b0;
      image_valid  <= 1'b0;
      filter_size  <= 1'b0;
      image_size   <= '0;
      pad_mode     <= 1'b0;
      act_mode     <= 1'b0;
      in_data      <= '0;
    end else begin
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      timeout_err <= 1'b0;
      if (state != IDLE) res_cnt <= res_next;

      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              filter_size  <= cfg_filter_size;
              image_size   <= cfg_image_size;
              pad_mode     <= cfg_pad_mode;
              act_mode     <= cfg_act_mode;
              nn           <= img_sq;
              busy         <= 1'b1;
              filter_valid <= 1'b1;
              in_data      <= filt_rdata;
              idx          <= 7'd1;
              res_cnt      <= '0;
              wdog         <= '0;
              state        <= SEND_FILT;
            end
          end
        end
        SEND_FILT: begin
          if (idx == {2'b00, filt_len(filter_size)}) begin
            filter_valid <= 1'b0;
            in_data      <= '0;
            gap_cnt      <= 4'd1;
            state        <= GAP;
          end else begin
            in_data <= filt_rdata;
            idx     <= idx + 7'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 4'(GAP_CYC)) begin
            image_valid <= 1'b1;
            in_data     <= img_rdata;
            idx         <= 7'd1;
            state       <= SEND_IMG;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        SEND_IMG: begin
          if (idx == nn) begin
            image_valid <= 1'b0;
            in_data     <= '0;
            wdog        <= '0;
            state       <= WAIT_OUT;
          end else begin
            in_data <= img_rdata;
            idx     <= idx + 7'd1;
          end
        end
        WAIT_OUT: begin
          if (conv_out_valid) wdog <= '0;
          else                wdog <= wdog + 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (end_ok || end_tmo) begin
        state       <= IDLE;
        busy        <= 1'b0;
        done        <= 1'b1;
        timeout_err <= end_tmo;
        filter_size <= 1'b0;
        image_size  <= '0;
        pad_mode    <= 1'b0;
        act_mode    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_feeder.sv
// Directed bench for conv_feeder: two instances (gap 1 and gap 3) driven by
// a cycle-by-cycle job monitor with a small engine result model.
module tb_conv_feeder;
  import conv_pkg::*;

  localparam int TMO = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_we, host_sel;
  logic [5:0] host_addr;
  logic [7:0] host_wdata;
  logic       start_a, start_b;
  logic       cfg_filter_size, cfg_pad_mode, cfg_act_mode;
  logic [3:0] cfg_image_size;
  logic       cov_a, cov_b;

  logic       a_busy, a_done, a_cerr, a_terr, a_fv, a_iv, a_fsz, a_pad, a_act;
  logic [3:0] a_isz;
  logic [7:0] a_dat;
  logic       b_busy, b_done, b_cerr, b_terr, b_fv, b_iv, b_fsz, b_pad, b_act;
  logic [3:0] b_isz;
  logic [7:0] b_dat;

  logic [7:0] fm [25];
  logic [7:0] im [64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_feeder #(.MAX_IMG(8), .GAP_CYC(1), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr),
    .host_wdata(host_wdata), .start(start_a), .cfg_filter_size(cfg_filter_size),
    .cfg_image_size(cfg_image_size), .cfg_pad_mode(cfg_pad_mode), .cfg_act_mode(cfg_act_mode),
    .busy(a_busy), .done(a_done), .cfg_err(a_cerr), .timeout_err(a_terr),
    .filter_valid(a_fv), .image_valid(a_iv), .filter_size(a_fsz), .image_size(a_isz),
    .pad_mode(a_pad), .act_mode(a_act), .in_data(a_dat), .conv_out_valid(cov_a)
  );

  conv_feeder #(.MAX_IMG(8), .GAP_CYC(3), .TIMEOUT(TMO)) dut3 (
    .clk(clk), .rst(rst), .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr),
    .host_wdata(host_wdata), .start(start_b), .cfg_filter_size(cfg_filter_size),
    .cfg_image_size(cfg_image_size), .cfg_pad_mode(cfg_pad_mode), .cfg_act_mode(cfg_act_mode),
    .busy(b_busy), .done(b_done), .cfg_err(b_cerr), .timeout_err(b_terr),
    .filter_valid(b_fv), .image_valid(b_iv), .filter_size(b_fsz), .image_size(b_isz),
    .pad_mode(b_pad), .act_mode(b_act), .in_data(b_dat), .conv_out_valid(cov_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic host_write(input logic sel, input int addr, input logic [7:0] data);
    @(negedge clk);
    host_we = 1'b1; host_sel = sel; host_addr = 6'(addr); host_wdata = data;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic check_a_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(a_busy), 0);
    check({tag, "_done"}, 32'(a_done), 0);
    check({tag, "_valids"}, {30'd0, a_fv, a_iv}, 0);
    check({tag, "_in_data"}, 32'(a_dat), 0);
    check({tag, "_cfg"}, {25'd0, a_fsz, a_isz, a_pad, a_act}, 0);
    check({tag, "_errs"}, {30'd0, a_cerr, a_terr}, 0);
    check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  // Runs one job on instance `which` (0 = gap 1, 1 = gap 3), modelling the engine:
  // result pulses start after the second image byte, one per cycle, `pulses` in total.
  task automatic run_job(input bit which, input logic fs, input int n, input int pulses,
                         input int inject_at, input int rst_at, input int exp_gap,
                         input bit exp_tmo);
    int nf = fs ? 25 : 9;
    int fcnt = 0, gcnt = 0, icnt = 0, sent = 0, cyc = 0;
    int last_img = -1, last_pulse = -1, done_cyc = -1;
    int nz = 0, cfg_bad = 0, cerr_seen = 0, prev_bz = 0;
    bit inj_done = 0, inj_clear = 0, tmo_seen = 0, bz_at_done = 1;
    logic fv, iv, dn, te, bz, ce, cv;
    logic [7:0] dat;
    logic [6:0] cfg_now, cfg_first;

    @(negedge clk);
    cfg_filter_size = fs; cfg_image_size = 4'(n); cfg_pad_mode = 1'b1; cfg_act_mode = 1'b1;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    cfg_first = '0;

    while (cyc < 2000) begin
      fv  = which ? b_fv   : a_fv;
      iv  = which ? b_iv   : a_iv;
      dn  = which ? b_done : a_done;
      te  = which ? b_terr : a_terr;
      bz  = which ? b_busy : a_busy;
      ce  = which ? b_cerr : a_cerr;
      dat = which ? b_dat  : a_dat;
      cfg_now = which ? {b_fsz, b_isz, b_pad, b_act} : {a_fsz, a_isz, a_pad, a_act};

      if (cyc == 0) begin
        check("first_filter_valid", 32'(fv), 1);
        check("first_busy", 32'(bz), 1);
        check("first_cfg", 32'(cfg_now), {25'd0, fs, 4'(n), 1'b1, 1'b1});
        cfg_first = cfg_now;
      end
      if (bz && cfg_now != cfg_first) cfg_bad++;
      if (ce) cerr_seen++;
      if (!fv && !iv && dat != 8'd0) nz++;
      if (fv) begin
        check("filt_data", 32'(dat), 32'(fm[fcnt]));
        fcnt++;
      end
      if (!fv && !iv && fcnt == nf && icnt == 0 && !dn) gcnt++;
      if (iv) begin
        check("img_data", 32'(dat), 32'(im[icnt]));
        icnt++;
        last_img = cyc;
      end
      if (dn) begin
        done_cyc = cyc; tmo_seen = te; bz_at_done = bz;
        break;
      end
      prev_bz = int'(bz);

      if (rst_at > 0 && icnt == rst_at) begin
        cov_a = 1'b0; cov_b = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_a_outputs_zero("mid_reset");
        return;
      end

      if (inj_clear) begin
        start_a = 1'b0; start_b = 1'b0; host_we = 1'b0; inj_clear = 0;
      end
      if (inject_at > 0 && icnt == inject_at && !inj_done) begin
        if (which) start_b = 1'b1; else start_a = 1'b1;
        host_we = 1'b1; host_sel = 1'b0; host_addr = 6'd0; host_wdata = 8'h7F;
        inj_done = 1; inj_clear = 1;
      end

      cv = (sent < pulses) && (icnt >= 2);
      if (which) cov_b = cv; else cov_a = cv;
      if (cv) begin sent++; last_pulse = cyc; end

      @(negedge clk);
      cyc++;
    end
    cov_a = 1'b0; cov_b = 1'b0;

    check("filt_count", 32'(fcnt), 32'(nf));
    check("gap_cycles", 32'(gcnt), 32'(exp_gap));
    check("img_count", 32'(icnt), 32'(n * n));
    check("idle_data_zero", 32'(nz), 0);
    check("cfg_stable", 32'(cfg_bad), 0);
    check("no_cfg_err_busy", 32'(cerr_seen), 0);
    if (exp_tmo) check("done_cycle_tmo", 32'(done_cyc), 32'(last_img + 1 + TMO));
    else         check("done_cycle", 32'(done_cyc), 32'(last_pulse + 1));
    check("timeout_err", 32'(tmo_seen), 32'(exp_tmo));
    check("busy_fall_at_done", {30'd0, bz_at_done, prev_bz[0]}, 32'b01);
    check("state_after_done", which ? 32'(dut3.state) : 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    check("done_one_cycle", which ? 32'(b_done) : 32'(a_done), 0);
  endtask

  task automatic bad_start(input logic [3:0] size, input string tag);
    @(negedge clk);
    cfg_filter_size = 1'b0; cfg_image_size = size; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check({tag, "_cfg_err"}, 32'(a_cerr), 1);
    check({tag, "_busy"}, 32'(a_busy), 0);
    check({tag, "_valids"}, {30'd0, a_fv, a_iv}, 0);
    @(negedge clk);
    check({tag, "_cfg_err_pulse"}, 32'(a_cerr), 0);
    check({tag, "_still_idle"}, {30'd0, a_busy, a_fv | a_iv}, 0);
  endtask

  initial begin
    rst = 1'b1; host_we = 1'b0; host_sel = 1'b0; host_addr = '0; host_wdata = '0;
    start_a = 1'b0; start_b = 1'b0; cfg_filter_size = 1'b0; cfg_image_size = '0;
    cfg_pad_mode = 1'b0; cfg_act_mode = 1'b0; cov_a = 1'b0; cov_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_a_outputs_zero("reset");
    check("reset_b", {28'd0, b_busy, b_done, b_fv, b_iv}, 0);

    for (int k = 0; k < 25; k++) begin
      fm[k] = 8'(k + 1);
      host_write(1'b0, k, fm[k]);
    end
    for (int p = 0; p < 64; p++) begin
      im[p] = 8'(p);
      host_write(1'b1, p, im[p]);
    end

    run_job(1'b1, 1'b1, 8, 64, -1, -1, 3, 1'b0);   // 5x5, N=8, gap 3
    run_job(1'b0, 1'b0, 4, 16, -1, -1, 1, 1'b0);   // 3x3, N=4
    bad_start(4'd0, "size0");
    bad_start(4'd9, "size9");
    run_job(1'b0, 1'b0, 4, 16, 3, -1, 1, 1'b0);    // start + write while streaming
    run_job(1'b0, 1'b0, 4, 16, -1, -1, 1, 1'b0);   // filter[0] must still be 1
    run_job(1'b0, 1'b0, 4, 10, -1, -1, 1, 1'b1);   // watchdog
    run_job(1'b0, 1'b0, 4, 16, -1, 5, 1, 1'b0);    // reset on 5th image byte
    run_job(1'b0, 1'b0, 4, 16, -1, -1, 1, 1'b0);   // full replay after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
